// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with chained multi-slot lookup, saturating
// direction counters, retire-time training and a one-set-per-cycle bulk invalidate.
module btb_assoc #(
  parameter int ADDR_WIDTH  = 32,
  parameter int SETS        = 16,
  parameter int WAYS        = 2,
  parameter int FETCH_WIDTH = 2,
  parameter int CTR_BITS    = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [ADDR_WIDTH-1:0]             pc,
  input  logic                              pc_valid,
  output logic [FETCH_WIDTH-1:0]            pred_taken,
  output logic [FETCH_WIDTH*ADDR_WIDTH-1:0] pred_target,
  input  logic                              upd_valid,
  input  logic [ADDR_WIDTH-1:0]             upd_pc,
  input  logic [ADDR_WIDTH-1:0]             upd_target,
  input  logic                              upd_taken,
  input  logic                              inv_req,
  output logic                              inv_busy
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] sweep_cnt_reg;

  logic                  valid_reg  [SETS][WAYS];
  logic [TAG_W-1:0]      tag_reg    [SETS][WAYS];
  logic [ADDR_WIDTH-1:0] target_reg [SETS][WAYS];
  logic [CTR_BITS-1:0]   ctr_reg    [SETS][WAYS];
  logic [WAY_W-1:0]      victim_reg [SETS];

  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic [WAY_W-1:0] hit_way;
  logic             free_found;
  logic [WAY_W-1:0] free_way;
  logic [WAY_W-1:0] alloc_way;

  assign inv_busy = (state_reg == SWEEP);

  // Each slot looks up the address predicted by the slot before it.
  always_comb begin : lookup
    logic [ADDR_WIDTH-1:0] addr;
    logic [IDX_W-1:0]      lk_idx;
    logic [TAG_W-1:0]      lk_tag;
    logic                  lk_taken;
    logic [ADDR_WIDTH-1:0] lk_target;
    addr        = pc;
    pred_taken  = '0;
    pred_target = '0;
    lk_idx      = '0;
    lk_tag      = '0;
    lk_taken    = 1'b0;
    lk_target   = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      lk_idx    = addr[IDX_W+1:2];
      lk_tag    = addr[ADDR_WIDTH-1:IDX_W+2];
      lk_taken  = 1'b0;
      lk_target = addr + ADDR_WIDTH'(4);
      for (int w = 0; w < WAYS; w++) begin
        if (pc_valid && !inv_busy && valid_reg[lk_idx][w] &&
            tag_reg[lk_idx][w] == lk_tag && ctr_reg[lk_idx][w][CTR_BITS-1]) begin
          lk_taken  = 1'b1;
          lk_target = target_reg[lk_idx][w];
        end
      end
      pred_taken[k]                            = lk_taken;
      pred_target[k*ADDR_WIDTH +: ADDR_WIDTH]  = lk_target;
      addr                                     = lk_target;
    end
  end

  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[ADDR_WIDTH-1:IDX_W+2];

  // Descending scan so the lowest-numbered invalid way wins.
  always_comb begin
    upd_hit    = 1'b0;
    hit_way    = '0;
    free_found = 1'b0;
    free_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_reg[upd_idx][w] && tag_reg[upd_idx][w] == upd_tag) begin
        upd_hit = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_reg[upd_idx][w]) begin
        free_found = 1'b1;
        free_way   = WAY_W'(w);
      end
    end
    alloc_way = free_found ? free_way : victim_reg[upd_idx];
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (inv_req) state_next = SWEEP;
      SWEEP:   if (sweep_cnt_reg == IDX_W'(SETS - 1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      sweep_cnt_reg <= '0;
      for (int s = 0; s < SETS; s++) begin
        victim_reg[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          valid_reg[s][w]  <= 1'b0;
          tag_reg[s][w]    <= '0;
          target_reg[s][w] <= '0;
          ctr_reg[s][w]    <= '0;
        end
      end
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE) sweep_cnt_reg <= '0;
      else                   sweep_cnt_reg <= sweep_cnt_reg + IDX_W'(1);

      if (state_reg == SWEEP) begin
        victim_reg[sweep_cnt_reg] <= '0;
        for (int w = 0; w < WAYS; w++) valid_reg[sweep_cnt_reg][w] <= 1'b0;
      end else if (upd_valid) begin
        if (upd_hit) begin
          if (upd_taken) begin
            target_reg[upd_idx][hit_way] <= upd_target;
            if (ctr_reg[upd_idx][hit_way] != '1)
              ctr_reg[upd_idx][hit_way] <= ctr_reg[upd_idx][hit_way] + CTR_BITS'(1);
          end else if (ctr_reg[upd_idx][hit_way] != '0) begin
            ctr_reg[upd_idx][hit_way] <= ctr_reg[upd_idx][hit_way] - CTR_BITS'(1);
          end
        end else if (upd_taken) begin
          valid_reg[upd_idx][alloc_way]  <= 1'b1;
          tag_reg[upd_idx][alloc_way]    <= upd_tag;
          target_reg[upd_idx][alloc_way] <= upd_target;
          ctr_reg[upd_idx][alloc_way]    <= CTR_WEAK;
          // Round-robin advances only when a live entry is displaced.
          if (!free_found) begin
            if (victim_reg[upd_idx] == WAY_W'(WAYS - 1)) victim_reg[upd_idx] <= '0;
            else victim_reg[upd_idx] <= victim_reg[upd_idx] + WAY_W'(1);
          end
        end
      end
    end
  end

endmodule
